// File: rtl/pipe_pkg.sv
// Shared definitions for the instruction assembler: FSM states, word width
// and the opcode bit that marks a two-word (opcode + immediate) instruction.
package pipe_pkg;

    localparam int WORD_W       = 16;
    localparam int IMM_FLAG_BIT = 15;

    typedef enum logic [1:0] {
        S_OP   = 2'd0,
        S_IMM  = 2'd1,
        S_FULL = 2'd2
    } state_t;

endpackage

// File: rtl/instr_assembler.sv
// Joins 16-bit fetch words into complete instructions (opcode plus optional immediate).
// Define INSTR_ASM_PC_TAG_EN to tag each instruction with its opcode address on out_pc.
module instr_assembler
    import pipe_pkg::*;
(
    input  logic              clk,
    input  logic              rst,
    input  logic              flush,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [WORD_W-1:0] in_word,
    input  logic [31:0]       in_pc,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [WORD_W-1:0] out_instr,
    output logic [WORD_W-1:0] out_imm,
    output logic              out_has_imm
`ifdef INSTR_ASM_PC_TAG_EN
    ,
    output logic [31:0]       out_pc
`endif
);

    state_t            state_q, state_d;
    logic [WORD_W-1:0] instr_q, instr_d;
    logic [WORD_W-1:0] imm_q, imm_d;
    logic              has_imm_q, has_imm_d;
    logic              accept;

    // A held instruction only blocks input when decode is not taking it this cycle.
    assign in_ready = !rst && !flush && ((state_q != S_FULL) || out_ready);
    assign accept   = in_valid && in_ready;

    always_comb begin
        state_d   = state_q;
        instr_d   = instr_q;
        imm_d     = imm_q;
        has_imm_d = has_imm_q;
        if (flush) begin
            state_d = S_OP;
        end else begin
            if (state_q == S_FULL && out_ready && !accept) begin
                state_d = S_OP;
            end
            if (accept) begin
                if (state_q == S_IMM) begin
                    imm_d   = in_word;
                    state_d = S_FULL;
                end else begin
                    instr_d   = in_word;
                    imm_d     = '0;
                    has_imm_d = in_word[IMM_FLAG_BIT];
                    state_d   = in_word[IMM_FLAG_BIT] ? S_IMM : S_FULL;
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= S_OP;
            instr_q   <= '0;
            imm_q     <= '0;
            has_imm_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            instr_q   <= instr_d;
            imm_q     <= imm_d;
            has_imm_q <= has_imm_d;
        end
    end

    assign out_valid   = (state_q == S_FULL);
    assign out_instr   = instr_q;
    assign out_imm     = imm_q;
    assign out_has_imm = has_imm_q;

`ifdef INSTR_ASM_PC_TAG_EN
    logic [31:0] pc_q, pc_d;

    // The address travels with the opcode word, never with the immediate.
    always_comb begin
        pc_d = pc_q;
        if (!flush && accept && state_q != S_IMM) begin
            pc_d = in_pc;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            pc_q <= '0;
        end else begin
            pc_q <= pc_d;
        end
    end

    assign out_pc = pc_q;
`else
    logic unused_pc;
    assign unused_pc = ^in_pc;
`endif

endmodule

// File: tb/tb_instr_assembler.sv
// Self-checking bench for instr_assembler: directed vector table, a stall
// sequence, then randomized traffic against a behavioural instruction model.
module tb_instr_assembler;

    logic        clk;
    logic        rst;
    logic        flush;
    logic        in_valid;
    logic        in_ready;
    logic [15:0] in_word;
    logic [31:0] in_pc;
    logic        out_valid;
    logic        out_ready;
    logic [15:0] out_instr;
    logic [15:0] out_imm;
    logic        out_has_imm;
`ifdef INSTR_ASM_PC_TAG_EN
    logic [31:0] out_pc;
`endif

    instr_assembler dut (
        .clk        (clk),
        .rst        (rst),
        .flush      (flush),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .in_word    (in_word),
        .in_pc      (in_pc),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_instr  (out_instr),
        .out_imm    (out_imm),
        .out_has_imm(out_has_imm)
`ifdef INSTR_ASM_PC_TAG_EN
        ,
        .out_pc     (out_pc)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_vec = 0;
    int n_err = 0;

    // Behavioural model: a held instruction plus "waiting for immediate" flag.
    logic        m_valid, m_wait;
    logic [15:0] m_instr, m_imm;
    logic        m_has;
    logic [31:0] m_pc;
    logic        m_rdy;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    task automatic model_step(input logic r, input logic f, input logic iv,
                              input logic ordy, input logic [15:0] w, input logic [31:0] pc);
        logic acc;
        acc = iv && m_rdy;
        if (r) begin
            m_valid = 0; m_wait = 0; m_instr = 0; m_imm = 0; m_has = 0; m_pc = 0;
        end else if (f) begin
            m_valid = 0; m_wait = 0;
        end else begin
            if (m_valid && ordy) m_valid = 0;
            if (acc) begin
                if (m_wait) begin
                    m_imm = w; m_wait = 0; m_valid = 1;
                end else begin
                    m_instr = w; m_imm = 0; m_has = w[15]; m_pc = pc;
                    if (w[15]) m_wait = 1; else m_valid = 1;
                end
            end
        end
    endtask

    // One clock: drive inputs, check in_ready, clock, advance model.
    task automatic step(input logic r, input logic f, input logic iv,
                        input logic ordy, input logic [15:0] w, input logic [31:0] pc,
                        input bit chk_rdy_model);
        @(negedge clk);
        rst = r; flush = f; in_valid = iv; out_ready = ordy; in_word = w; in_pc = pc;
        m_rdy = !r && !f && (!m_valid || ordy);
        #1;
        if (chk_rdy_model) check("in_ready_model", {31'b0, in_ready}, {31'b0, m_rdy});
        @(posedge clk);
        model_step(r, f, iv, ordy, w, pc);
        #1;
    endtask

    task automatic check_model_outputs();
        check("out_valid_model", {31'b0, out_valid}, {31'b0, m_valid});
        if (m_valid) begin
            check("out_instr_model", {16'b0, out_instr}, {16'b0, m_instr});
            check("out_imm_model", {16'b0, out_imm}, {16'b0, m_imm});
            check("out_has_imm_model", {31'b0, out_has_imm}, {31'b0, m_has});
`ifdef INSTR_ASM_PC_TAG_EN
            check("out_pc_model", out_pc, m_pc);
`endif
        end
    endtask

    typedef struct {
        logic        r, f, iv, ordy;
        logic [15:0] w;
        logic [31:0] pc;
        logic        e_rdy;
        logic        e_ov;
        bit          chk_out;
        logic [15:0] e_instr, e_imm;
        logic        e_has;
        logic [31:0] e_pc;
    } vec_t;

    vec_t vt[13];

    initial begin
        logic [15:0] held_instr, held_imm;
        logic        held_has;
        logic [15:0] rw;

        m_valid = 0; m_wait = 0; m_instr = 0; m_imm = 0; m_has = 0; m_pc = 0; m_rdy = 0;
        rst = 1; flush = 0; in_valid = 0; out_ready = 0; in_word = 0; in_pc = 0;

        //          r  f  iv or  word      pc     rdy ov chk instr     imm       has pc
        vt[0]  = '{1, 0, 1, 1, 16'h1234, 32'h00, 0, 0, 1, 16'h0000, 16'h0000, 0, 32'h00};
        vt[1]  = '{0, 0, 1, 1, 16'h1234, 32'h10, 1, 1, 1, 16'h1234, 16'h0000, 0, 32'h10};
        vt[2]  = '{0, 0, 1, 1, 16'h8A01, 32'h20, 1, 0, 0, 16'h0000, 16'h0000, 0, 32'h00};
        vt[3]  = '{0, 0, 1, 1, 16'h00FF, 32'h22, 1, 1, 1, 16'h8A01, 16'h00FF, 1, 32'h20};
        vt[4]  = '{0, 0, 1, 1, 16'h8A01, 32'h24, 1, 0, 0, 16'h0000, 16'h0000, 0, 32'h00};
        vt[5]  = '{0, 1, 1, 1, 16'h00FF, 32'h26, 0, 0, 0, 16'h0000, 16'h0000, 0, 32'h00};
        vt[6]  = '{0, 0, 1, 1, 16'h0042, 32'h30, 1, 1, 1, 16'h0042, 16'h0000, 0, 32'h30};
        vt[7]  = '{0, 0, 1, 1, 16'h8123, 32'h32, 1, 0, 0, 16'h0000, 16'h0000, 0, 32'h00};
        vt[8]  = '{1, 0, 0, 0, 16'h0000, 32'h00, 0, 0, 1, 16'h0000, 16'h0000, 0, 32'h00};
        vt[9]  = '{0, 0, 0, 0, 16'h0000, 32'h00, 1, 0, 1, 16'h0000, 16'h0000, 0, 32'h00};
        vt[10] = '{0, 0, 1, 0, 16'h0077, 32'h40, 1, 1, 1, 16'h0077, 16'h0000, 0, 32'h40};
        vt[11] = '{1, 0, 1, 0, 16'h0088, 32'h42, 0, 0, 1, 16'h0000, 16'h0000, 0, 32'h00};
        vt[12] = '{0, 0, 0, 0, 16'h0000, 32'h00, 1, 0, 1, 16'h0000, 16'h0000, 0, 32'h00};

        for (int i = 0; i < 13; i++) begin
            @(negedge clk);
            rst = vt[i].r; flush = vt[i].f; in_valid = vt[i].iv; out_ready = vt[i].ordy;
            in_word = vt[i].w; in_pc = vt[i].pc;
            m_rdy = !vt[i].r && !vt[i].f && (!m_valid || vt[i].ordy);
            #1;
            check($sformatf("vec%0d_in_ready", i), {31'b0, in_ready}, {31'b0, vt[i].e_rdy});
            @(posedge clk);
            model_step(vt[i].r, vt[i].f, vt[i].iv, vt[i].ordy, vt[i].w, vt[i].pc);
            #1;
            check($sformatf("vec%0d_out_valid", i), {31'b0, out_valid}, {31'b0, vt[i].e_ov});
            if (vt[i].chk_out) begin
                check($sformatf("vec%0d_out_instr", i), {16'b0, out_instr}, {16'b0, vt[i].e_instr});
                check($sformatf("vec%0d_out_imm", i), {16'b0, out_imm}, {16'b0, vt[i].e_imm});
                check($sformatf("vec%0d_out_has_imm", i), {31'b0, out_has_imm}, {31'b0, vt[i].e_has});
`ifdef INSTR_ASM_PC_TAG_EN
                check($sformatf("vec%0d_out_pc", i), out_pc, vt[i].e_pc);
`endif
            end
            $display("vec %0d: rst=%b flush=%b in_valid=%b out_ready=%b word=%h -> in_ready=%b out_valid=%b instr=%h imm=%h has=%b",
                     i, vt[i].r, vt[i].f, vt[i].iv, vt[i].ordy, vt[i].w, in_ready, out_valid,
                     out_instr, out_imm, out_has_imm);
        end

        // Backpressure: held instruction must block input and stay stable.
        step(0, 0, 1, 0, 16'h0555, 32'h50, 1);
        check("stall_load_valid", {31'b0, out_valid}, 32'd1);
        for (int k = 0; k < 5; k++) begin
            step(0, 0, 1, 0, 16'h0666, 32'h52, 0);
            check("stall_in_ready", {31'b0, in_ready}, 32'd0);
            check("stall_out_valid", {31'b0, out_valid}, 32'd1);
            check("stall_out_instr", {16'b0, out_instr}, 32'h0555);
            $display("stall %0d: in_ready=%b out_valid=%b instr=%h", k, in_ready, out_valid, out_instr);
        end
        @(negedge clk);
        out_ready = 1; m_rdy = 1;
        #1;
        check("release_in_ready", {31'b0, in_ready}, 32'd1);
        @(posedge clk);
        model_step(0, 0, 1, 1, 16'h0666, 32'h52);
        #1;
        check("release_out_valid", {31'b0, out_valid}, 32'd1);
        check("release_out_instr", {16'b0, out_instr}, 32'h0666);
        $display("release: out_valid=%b instr=%h", out_valid, out_instr);

        // Throughput: one-word instructions back to back.
        for (int k = 0; k < 4; k++) begin
            step(0, 0, 1, 1, 16'h0100 + 16'(k), 32'h60 + 32'(2 * k), 1);
            check("stream_out_valid", {31'b0, out_valid}, 32'd1);
            check("stream_out_instr", {16'b0, out_instr}, 32'h0100 + 32'(k));
            $display("stream %0d: out_valid=%b instr=%h", k, out_valid, out_instr);
        end

        // Randomized traffic against the model.
        for (int k = 0; k < 3000; k++) begin
            rw = 16'($urandom);
            rw[15] = ($urandom_range(0, 9) < 4);
            step(($urandom_range(0, 63) == 0), ($urandom_range(0, 15) == 0),
                 ($urandom_range(0, 9) < 7), ($urandom_range(0, 9) < 7),
                 rw, $urandom, 1);
            check_model_outputs();
            if (k % 100 == 0)
                $display("rand %0d: out_valid=%b instr=%h imm=%h has=%b", k, out_valid,
                         out_instr, out_imm, out_has_imm);
        end
        held_instr = 0; held_imm = 0; held_has = 0;
        if (held_instr != 0 || held_imm != 0 || held_has != 0) $display("unreachable");

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/instr_assembler.md
INSTR_ASSEMBLER -- requirements
Module: instr_assembler

Interface
REQ-001 SHALL have port: clk  input  1  single clock; all state updates on rising edge.
REQ-002 SHALL have port: rst  input  1  reset, synchronous, active-high.
REQ-003 SHALL have port: flush  input  1  sync discard of partial/held instruction (branch/jump/interrupt redirect).
REQ-004 SHALL have port: in_valid  input  1  fetch presents a 16-bit word.
REQ-005 SHALL have port: in_ready  output  1  assembler accepts word this cycle.
REQ-006 SHALL have port: in_word  input  16  fetched instruction or immediate word.
REQ-007 SHALL have port: in_pc  input  32  address of in_word.
REQ-008 SHALL have port: out_valid  output  1  complete instruction held for decode.
REQ-009 SHALL have port: out_ready  input  1  decode consumes held instruction.
REQ-010 SHALL have port: out_instr  output  16  opcode word.
REQ-011 SHALL have port: out_imm  output  16  immediate word; 16'h0000 when none.
REQ-012 SHALL have port: out_has_imm  output  1  instruction carried an immediate.
REQ-013 SHALL have port: out_pc  output  32  address of opcode word (present only with INSTR_ASM_PC_TAG_EN).

Function
REQ-014 SHALL transfer a word only when in_valid && in_ready; an instruction only when out_valid && out_ready.
REQ-015 SHALL treat an opcode word as two-word when in_word[IMM_FLAG_BIT]=1 (IMM_FLAG_BIT=15); next accepted word is its immediate, regardless of that word's bit 15.
REQ-016 SHALL implement FSM states S_OP (expect opcode), S_IMM (opcode captured, expect immediate), S_FULL (complete instruction held).
REQ-017 SHALL transition S_OP->S_FULL on accepted one-word opcode; S_OP->S_IMM on accepted two-word opcode; S_IMM->S_FULL on accepted immediate.
REQ-018 SHALL in S_FULL on out_ready: go to S_OP if no word accepted, else capture accepted word as new opcode and go to S_FULL or S_IMM per REQ-015.
REQ-019 SHALL drive in_ready = !flush && (state!=S_FULL || out_ready); combinational, no registered bubble.
REQ-020 SHALL drive out_valid=1 exactly in S_FULL; out_* stable while out_valid && !out_ready.
REQ-021 SHALL deliver latency 1: one-word opcode accepted cycle N -> out_valid cycle N+1; immediate accepted cycle M -> out_valid M+1.
REQ-022 SHALL sustain one one-word instruction per cycle when in_valid and out_ready held high.
REQ-023 SHALL on flush (any state): next state S_OP, out_valid=0 next cycle, captured words discarded; flush overrides simultaneous in_valid and out_ready.
REQ-024 SHALL hold state in S_IMM indefinitely while in_valid=0 (fetch stall); no timeout.

Reset
REQ-025 SHALL on rst: state S_OP, out_valid=0, out_instr=0, out_imm=0, out_has_imm=0, out_pc=0.
REQ-026 SHALL give rst priority over flush and all handshakes; reset mid-S_IMM discards captured opcode.
REQ-027 SHALL drive in_ready=0 during the rst cycle.

Configuration
REQ-028 SHALL with INSTR_ASM_PC_TAG_EN defined: capture in_pc with each opcode word and present it on out_pc with the instruction.
REQ-029 SHALL without INSTR_ASM_PC_TAG_EN: omit out_pc and its 32-bit register; all other behaviour identical; in_pc ignored.

Structure
REQ-030 SHALL place FSM state typedef (S_OP, S_IMM, S_FULL), IMM_FLAG_BIT and word width constant (16) in shared package pipe_pkg.
REQ-031 SHALL be a single module; no sub-module.

Verification
REQ-032 SHALL test: rst, then word 16'h1234 accepted cycle 1, out_ready=1 -> cycle 2 out_valid=1, out_instr=16'h1234, out_has_imm=0, out_imm=0.
REQ-033 SHALL test: 16'h8A01 then 16'h00FF back-to-back -> one instruction, out_instr=16'h8A01, out_imm=16'h00FF, out_has_imm=1, valid one cycle after 16'h00FF.
REQ-034 SHALL test: out_ready=0 with held instruction, in_valid=1 -> in_ready=0, out_* unchanged 5 cycles; out_ready=1 -> next word accepted same cycle.
REQ-035 SHALL test: 16'h8A01 accepted, flush next cycle with in_valid=1 -> word dropped, then 16'h0042 -> out_instr=16'h0042, out_has_imm=0.
REQ-036 SHALL test: rst asserted while in S_IMM and while out_valid=1 -> next cycle out_valid=0, all outputs 0, in_ready=1.
REQ-037 SHALL test with INSTR_ASM_PC_TAG_EN: 16'h8A01 at in_pc=32'h20, immediate at 32'h22 -> out_pc=32'h20.
